// File: rtl/serial_adder_ctrl_if.sv
// Command/result bundle between a command source and the bit-serial adder sequencer.
// Master drives the operands and start request, slave returns busy/done and the held result.
// Carries no state of its own; purely a port grouping.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, sub, op_a, op_b, c_in,
    input  busy, done, result, c_out, overflow
  );

  modport slave (
    input  start, sub, op_a, op_b, c_in,
    output busy, done, result, c_out, overflow
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer time-sharing one full-adder cell, LSB first.
// Latency: start accepted at edge T -> done pulse in cycle T+WIDTH+1; busy for T+1..T+WIDTH+1.
// No queuing: start and operand changes are ignored while busy; caller must wait for busy=0.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  serial_adder_ctrl_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum_sr;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic               r_c_out;
  logic               r_overflow;

  logic               w_sum;
  logic               w_cout;
  logic               w_last;
  logic [WIDTH-1:0]   w_sum_next;

  // The shared full-adder cell, fed from the LSBs of the operand shift registers.
  assign w_sum      = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_cout     = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_sum_next = {w_sum, r_sum_sr[WIDTH-1:1]};

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.c_out    = r_c_out;
  assign bus.overflow = r_overflow;

  // Sequencer: load on accept, one adder bit per RUN cycle, publish on entry to DONE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_sum_sr   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_c_out    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.op_a;
            // Subtract as a + ~b + 1: invert B and force the carry-in.
            r_b     <= bus.sub ? ~bus.op_b : bus.op_b;
            r_carry <= bus.sub ? 1'b1 : bus.c_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum_sr <= w_sum_next;
          r_a      <= {1'b0, r_a[WIDTH-1:1]};
          r_b      <= {1'b0, r_b[WIDTH-1:1]};
          r_carry  <= w_cout;
          if (w_last) begin
            // r_carry here is the carry into the MSB; w_cout is the carry out of it.
            r_result   <= w_sum_next;
            r_c_out    <= w_cout;
            r_overflow <= r_carry ^ w_cout;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized + directed bench for serial_adder_ctrl (WIDTH=8) with a queue scoreboard.
// Driver pushes expected result and done cycle on every accepted start; monitor pops on done.
// Monitor also checks held outputs stay stable between done pulses and clear on reset.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    int           cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  logic rst_at_edge;
  int   n_cmp;
  int   n_fail;
  int   done_seen;
  exp_t q[$];

  logic [W-1:0] held_res;
  logic         held_co;
  logic         held_ov;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         = cyc + 1;
    rst_at_edge = rst_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the true unsigned and signed values.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sb);
    exp_t m;
    int ua, ub, sa, sbv, u, s;
    ua  = a;
    ub  = b;
    sa  = $signed(a);
    sbv = $signed(b);
    if (sb) begin
      u = ua - ub + 256;
      s = sa - sbv;
    end else begin
      u = ua + ub + ci;
      s = sa + sbv + ci;
    end
    m.res = u[7:0];
    m.co  = u[8];
    m.ov  = (s > 127) || (s < -128);
    m.cyc = 0;
    return m;
  endfunction

  // Monitor: runs on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (!rst_at_edge) begin
        held_res = '0;
        held_co  = 1'b0;
        held_ov  = 1'b0;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_result", bus.result, 0);
        check("reset_cout", bus.c_out, 0);
        check("reset_ovf", bus.overflow, 0);
      end else if (bus.done) begin
        done_seen++;
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("result", bus.result, e.res);
          check("c_out", bus.c_out, e.co);
          check("overflow", bus.overflow, e.ov);
          check("done_cycle", cyc, e.cyc);
          check("busy_in_done", bus.busy, 1);
          held_res = e.res;
          held_co  = e.co;
          held_ov  = e.ov;
        end
      end else begin
        check("hold_result", bus.result, held_res);
        check("hold_cout", bus.c_out, held_co);
        check("hold_ovf", bus.overflow, held_ov);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse start for one cycle without expecting acceptance (caller knows DUT is busy).
  task automatic stray_start();
    bus.start = 1'b1;
    bus.sub   = $urandom_range(0, 1);
    bus.op_a  = $urandom_range(0, 255);
    bus.op_b  = $urandom_range(0, 255);
    bus.c_in  = $urandom_range(0, 1);
    wait_cycles(1);
    bus.start = 1'b0;
  endtask

  // Wait for idle, issue one operation, record its expected response.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sb);
    int n;
    exp_t e;
    n = 0;
    while (bus.busy && n < 50) begin
      wait_cycles(1);
      n++;
    end
    if (n >= 50) check("idle_timeout", 1, 0);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.c_in  = ci;
    bus.sub   = sb;
    bus.start = 1'b1;
    e     = model(a, b, ci, sb);
    e.cyc = cyc + W + 1;
    q.push_back(e);
    wait_cycles(1);
    bus.start = 1'b0;
    bus.op_a  = $urandom_range(0, 255);
    bus.op_b  = $urandom_range(0, 255);
    bus.c_in  = $urandom_range(0, 1);
    bus.sub   = $urandom_range(0, 1);
    check("busy_after_accept", bus.busy, 1);
  endtask

  initial begin
    int n;
    int d0;
    cyc         = 0;
    n_cmp       = 0;
    n_fail      = 0;
    done_seen   = 0;
    rst_at_edge = 1'b1;
    held_res    = '0;
    held_co     = 1'b0;
    held_ov     = 1'b0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.sub     = 1'b0;
    bus.op_a    = '0;
    bus.op_b    = '0;
    bus.c_in    = 1'b0;

    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2);

    // Directed corner cases.
    issue(8'h0F, 8'h01, 1'b0, 1'b0);
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    issue(8'h00, 8'h00, 1'b1, 1'b0);
    issue(8'h7F, 8'h01, 1'b0, 1'b0);
    issue(8'h80, 8'h80, 1'b0, 1'b0);
    issue(8'h05, 8'h07, 1'b1, 1'b1);
    issue(8'h07, 8'h05, 1'b0, 1'b1);

    // Starts while busy (mid-RUN and in DONE) must be ignored; next start back-to-back.
    issue(8'h3C, 8'h5A, 1'b0, 1'b0);
    wait_cycles(2);
    stray_start();
    wait_cycles(5);
    check("in_done_cycle", bus.done, 1);
    stray_start();
    issue(8'h12, 8'h34, 1'b1, 1'b0);

    // Reset in the middle of RUN aborts without a done pulse.
    issue(8'hAA, 8'h55, 1'b0, 1'b0);
    wait_cycles(3);
    d0    = done_seen;
    rst_n = 1'b0;
    q.delete();
    wait_cycles(1);
    rst_n = 1'b1;
    wait_cycles(15);
    check("no_done_after_reset", done_seen, d0);

    // Randomized traffic with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      issue($urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 1), $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 12));
    end

    // Drain outstanding expectations.
    n = 0;
    while (q.size() != 0 && n < 200) begin
      wait_cycles(1);
      n++;
    end
    check("queue_drained", q.size(), 0);
    wait_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
